// File: rtl/scc_wave_memory_arbiter_pkg.sv
// Shared constants, request-source enum and id mapping helpers for the
// SCC wave memory arbiter.
package scc_pkg;

  localparam logic [2:0] SCC_CH_A = 3'd0;
  localparam logic [2:0] SCC_CH_B = 3'd1;
  localparam logic [2:0] SCC_CH_C = 3'd2;
  localparam logic [2:0] SCC_CH_D = 3'd3;
  localparam logic [2:0] SCC_CH_E = 3'd4;

  localparam int unsigned SCC_WAVE_AW = 5;
  localparam int unsigned SCC_RAM_AW  = 8;

  localparam logic [7:0] SCC_INVALID_Q = 8'hFF;

  typedef enum logic [1:0] {
    SRC_IDLE = 2'd0,
    SRC_CPU  = 2'd1,
    SRC_TONE = 2'd2
  } scc_src_e;

  // In SCC mode channel E has no wave of its own and shares channel D's.
  function automatic logic [2:0] scc_map_id(input logic [2:0] id, input logic scci);
    scc_map_id = (id == SCC_CH_E && !scci) ? SCC_CH_D : id;
  endfunction

  function automatic logic scc_id_valid(input logic [2:0] id);
    scc_id_valid = (id <= SCC_CH_E);
  endfunction

endpackage

// File: rtl/scc_wave_memory_arbiter_if.sv
// Bus bundle between the requesters/RAM (master) and the arbiter (slave).
interface scc_wave_memory_arbiter_if;
  import scc_pkg::*;

  logic [2:0]             cpu_id;
  logic [SCC_WAVE_AW-1:0] cpu_a;
  logic [7:0]             cpu_d;
  logic                   cpu_oe;
  logic                   cpu_we;
  logic [7:0]             cpu_q;
  logic                   cpu_q_en;

  logic                   tone_req;
  logic [2:0]             tone_id;
  logic [SCC_WAVE_AW-1:0] tone_a;
  logic                   tone_ack;
  logic [7:0]             tone_q;
  logic                   tone_q_en;

  logic [SCC_RAM_AW-1:0]  ram_a;
  logic [7:0]             ram_d;
  logic                   ram_we;
  logic [7:0]             ram_q;

  modport master (
    output cpu_id, cpu_a, cpu_d, cpu_oe, cpu_we,
    input  cpu_q, cpu_q_en,
    output tone_req, tone_id, tone_a,
    input  tone_ack, tone_q, tone_q_en,
    input  ram_a, ram_d, ram_we,
    output ram_q
  );

  modport slave (
    input  cpu_id, cpu_a, cpu_d, cpu_oe, cpu_we,
    output cpu_q, cpu_q_en,
    input  tone_req, tone_id, tone_a,
    output tone_ack, tone_q, tone_q_en,
    output ram_a, ram_d, ram_we,
    input  ram_q
  );

endinterface

// File: rtl/scc_wave_memory_arbiter_slot.sv
// Pending CPU access register: last pulse wins, and a saturating counter of
// how many cycles the access has been held off by tone fetches.
module scc_cpu_request_slot
  import scc_pkg::*;
(
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   cap_oe,
  input  logic                   cap_we,
  input  logic [2:0]             cap_id,
  input  logic [SCC_WAVE_AW-1:0] cap_a,
  input  logic [7:0]             cap_d,
  input  logic                   grant,
  output logic                   occupied,
  output logic [2:0]             slot_id,
  output logic [SCC_WAVE_AW-1:0] slot_a,
  output logic [7:0]             slot_d,
  output logic                   slot_wr,
  output logic [3:0]             wait_cnt
);

  logic                   valid_q;
  logic [2:0]             id_q;
  logic [SCC_WAVE_AW-1:0] a_q;
  logic [7:0]             d_q;
  logic                   wr_q;
  logic [3:0]             wait_q;
  logic                   capture;

  // A capture is visible in its own cycle so it can be granted immediately.
  always_comb begin
    capture  = cap_oe | cap_we;
    occupied = capture | valid_q;
    slot_id  = capture ? cap_id : id_q;
    slot_a   = capture ? cap_a  : a_q;
    slot_d   = capture ? cap_d  : d_q;
    slot_wr  = capture ? cap_we : wr_q;
    wait_cnt = capture ? 4'd0   : wait_q;
  end

  // Hold the pending access until granted; count deferred cycles.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      valid_q <= 1'b0;
      id_q    <= '0;
      a_q     <= '0;
      d_q     <= '0;
      wr_q    <= 1'b0;
      wait_q  <= '0;
    end else begin
      valid_q <= occupied & ~grant;
      if (capture) begin
        id_q <= cap_id;
        a_q  <= cap_a;
        d_q  <= cap_d;
        wr_q <= cap_we;
      end
      if (grant || !occupied)
        wait_q <= '0;
      else if (wait_cnt != 4'hF)
        wait_q <= wait_cnt + 4'd1;
      else
        wait_q <= wait_cnt;
    end
  end

endmodule

// File: rtl/scc_wave_memory_arbiter.sv
// Arbitrates the CPU register path and the tone generator onto the shared
// single-port wave RAM, with SCC channel D/E sharing and a fixed 2-cycle
// read return.
module scc_wave_memory_arbiter
  import scc_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic nreset,
  input  logic scci_enable,
  scc_wave_memory_arbiter_if.slave bus
);

  logic                   occupied;
  logic [2:0]             slot_id;
  logic [SCC_WAVE_AW-1:0] slot_a;
  logic [7:0]             slot_d;
  logic                   slot_wr;
  logic [3:0]             wait_cnt;

  scc_src_e               src;
  logic                   force_cpu;
  logic                   grant_cpu;
  logic [2:0]             sel_id;
  logic [SCC_WAVE_AW-1:0] sel_a;
  logic                   sel_invalid;
  logic                   is_write;
  logic                   do_write;
  logic                   do_read;

  logic [SCC_RAM_AW-1:0]  ram_a_q;
  logic [7:0]             ram_d_q;
  logic                   ram_we_q;
  logic                   rd_v;
  logic                   rd_cpu;
  logic                   rd_inv;
  logic [7:0]             cpu_q_q;
  logic                   cpu_q_en_q;
  logic [7:0]             tone_q_q;
  logic                   tone_q_en_q;

  scc_cpu_request_slot u_slot (
    .clk      (clk),
    .nreset   (nreset),
    .cap_oe   (bus.cpu_oe),
    .cap_we   (bus.cpu_we),
    .cap_id   (bus.cpu_id),
    .cap_a    (bus.cpu_a),
    .cap_d    (bus.cpu_d),
    .grant    (grant_cpu),
    .occupied (occupied),
    .slot_id  (slot_id),
    .slot_a   (slot_a),
    .slot_d   (slot_d),
    .slot_wr  (slot_wr),
    .wait_cnt (wait_cnt)
  );

  // Pick this cycle's RAM user: forced CPU, then tone, then idle CPU slot.
  // Gated by nreset so tone_ack stays low while reset is held.
  always_comb begin
    src       = SRC_IDLE;
    force_cpu = occupied && ({28'd0, wait_cnt} >= MAX_WAIT);
    if (nreset) begin
      if (force_cpu)
        src = SRC_CPU;
      else if (bus.tone_req)
        src = SRC_TONE;
      else if (occupied)
        src = SRC_CPU;
    end
  end

  assign grant_cpu    = (src == SRC_CPU);
  assign bus.tone_ack = (src == SRC_TONE);

  // Resolve the granted access; mode is taken at grant time.
  always_comb begin
    sel_id      = grant_cpu ? slot_id : bus.tone_id;
    sel_a       = grant_cpu ? slot_a  : bus.tone_a;
    sel_invalid = !scc_id_valid(sel_id);
    is_write    = grant_cpu & slot_wr;
    do_write    = is_write & !sel_invalid & !(sel_id == SCC_CH_E && !scci_enable);
    do_read     = (src != SRC_IDLE) & !is_write;
  end

  // Registered RAM command; address holds while idle.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ram_a_q  <= '0;
      ram_d_q  <= '0;
      ram_we_q <= 1'b0;
    end else begin
      ram_we_q <= do_write;
      if (src != SRC_IDLE)
        ram_a_q <= {scc_map_id(sel_id, scci_enable), sel_a};
      if (grant_cpu)
        ram_d_q <= slot_d;
    end
  end

  // Read return: tag in G+1, capture ram_q at the end of G+1, present in G+2.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rd_v        <= 1'b0;
      rd_cpu      <= 1'b0;
      rd_inv      <= 1'b0;
      cpu_q_q     <= '0;
      cpu_q_en_q  <= 1'b0;
      tone_q_q    <= '0;
      tone_q_en_q <= 1'b0;
    end else begin
      rd_v        <= do_read;
      rd_cpu      <= grant_cpu;
      rd_inv      <= sel_invalid;
      cpu_q_en_q  <= rd_v & rd_cpu;
      tone_q_en_q <= rd_v & ~rd_cpu;
      if (rd_v && rd_cpu)
        cpu_q_q <= rd_inv ? SCC_INVALID_Q : bus.ram_q;
      if (rd_v && !rd_cpu)
        tone_q_q <= rd_inv ? SCC_INVALID_Q : bus.ram_q;
    end
  end

  assign bus.ram_a     = ram_a_q;
  assign bus.ram_d     = ram_d_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.cpu_q     = cpu_q_q;
  assign bus.cpu_q_en  = cpu_q_en_q;
  assign bus.tone_q    = tone_q_q;
  assign bus.tone_q_en = tone_q_en_q;

endmodule

// File: tb/tb_scc_wave_memory_arbiter.sv
// Directed bench for scc_wave_memory_arbiter with a behavioural wave RAM.
module tb_scc_wave_memory_arbiter;

  logic clk;
  logic nreset;
  logic scci_enable;
  logic [7:0] mem [0:255];
  int total;
  int bad;

  scc_wave_memory_arbiter_if bus();

  scc_wave_memory_arbiter #(.MAX_WAIT(4)) dut (
    .clk         (clk),
    .nreset      (nreset),
    .scci_enable (scci_enable),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM read data follows the registered address; writes land on the edge.
  assign bus.ram_q = mem[bus.ram_a];
  always @(posedge clk) if (bus.ram_we) mem[bus.ram_a] <= bus.ram_d;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input string tag, input logic [2:0] id, input logic [4:0] a,
                           input logic [7:0] d, input logic exp_we, input logic [7:0] exp_a);
    bus.cpu_we = 1'b1; bus.cpu_id = id; bus.cpu_a = a; bus.cpu_d = d;
    step();
    bus.cpu_we = 1'b0;
    chk({tag, "_we"}, {7'd0, bus.ram_we}, {7'd0, exp_we});
    chk({tag, "_a"}, bus.ram_a, exp_a);
    if (exp_we) chk({tag, "_d"}, bus.ram_d, d);
    step();
    chk({tag, "_we_off"}, {7'd0, bus.ram_we}, 8'd0);
    chk({tag, "_noqen"}, {7'd0, bus.cpu_q_en}, 8'd0);
  endtask

  task automatic cpu_read(input string tag, input logic [2:0] id, input logic [4:0] a,
                          input logic [7:0] exp_a, input logic [7:0] exp_q);
    bus.cpu_oe = 1'b1; bus.cpu_id = id; bus.cpu_a = a;
    step();
    bus.cpu_oe = 1'b0;
    chk({tag, "_a"}, bus.ram_a, exp_a);
    chk({tag, "_we"}, {7'd0, bus.ram_we}, 8'd0);
    chk({tag, "_qen_early"}, {7'd0, bus.cpu_q_en}, 8'd0);
    step();
    chk({tag, "_qen"}, {7'd0, bus.cpu_q_en}, 8'd1);
    chk({tag, "_q"}, bus.cpu_q, exp_q);
    step();
    chk({tag, "_qen_off"}, {7'd0, bus.cpu_q_en}, 8'd0);
    chk({tag, "_q_hold"}, bus.cpu_q, exp_q);
  endtask

  task automatic tone_fetch(input string tag, input logic [2:0] id, input logic [4:0] a,
                            input logic [7:0] exp_a, input logic [7:0] exp_q);
    bus.tone_req = 1'b1; bus.tone_id = id; bus.tone_a = a;
    #1;
    chk({tag, "_ack"}, {7'd0, bus.tone_ack}, 8'd1);
    step();
    bus.tone_req = 1'b0;
    chk({tag, "_a"}, bus.ram_a, exp_a);
    step();
    chk({tag, "_qen"}, {7'd0, bus.tone_q_en}, 8'd1);
    chk({tag, "_q"}, bus.tone_q, exp_q);
    step();
    chk({tag, "_qen_off"}, {7'd0, bus.tone_q_en}, 8'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'hA0;
    mem[8'h01] = 8'h77;
    mem[8'h23] = 8'h3C;
    mem[8'h80] = 8'hE5;

    nreset = 1'b0; scci_enable = 1'b1;
    bus.cpu_id = '0; bus.cpu_a = '0; bus.cpu_d = '0; bus.cpu_oe = 1'b0; bus.cpu_we = 1'b0;
    bus.tone_req = 1'b1; bus.tone_id = '0; bus.tone_a = '0;

    // Reset state, tone_req high must not be acknowledged
    step(); step();
    chk("rst_ack", {7'd0, bus.tone_ack}, 8'd0);
    chk("rst_ram_a", bus.ram_a, 8'h00);
    chk("rst_ram_d", bus.ram_d, 8'h00);
    chk("rst_ram_we", {7'd0, bus.ram_we}, 8'd0);
    chk("rst_cpu_q", bus.cpu_q, 8'h00);
    chk("rst_cpu_qen", {7'd0, bus.cpu_q_en}, 8'd0);
    chk("rst_tone_q", bus.tone_q, 8'h00);
    chk("rst_tone_qen", {7'd0, bus.tone_q_en}, 8'd0);
    bus.tone_req = 1'b0;
    nreset = 1'b1;
    step();

    // Reset in the middle of a read: no q_en may surface
    bus.cpu_oe = 1'b1; bus.cpu_id = 3'd1; bus.cpu_a = 5'd3;
    step();
    bus.cpu_oe = 1'b0;
    chk("midrst_ram_a", bus.ram_a, 8'h23);
    nreset = 1'b0;
    #1;
    chk("midrst_ram_a0", bus.ram_a, 8'h00);
    chk("midrst_qen0", {7'd0, bus.cpu_q_en}, 8'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("midrst_qen_held", {7'd0, bus.cpu_q_en}, 8'd0);
    end
    nreset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midrst_qen_after", {7'd0, bus.cpu_q_en}, 8'd0);
      chk("midrst_we_after", {7'd0, bus.ram_we}, 8'd0);
    end

    // Write then read, tone idle
    cpu_write("wr_id2", 3'd2, 5'd5, 8'h5A, 1'b1, 8'h45);
    cpu_read("rd_id2", 3'd2, 5'd5, 8'h45, 8'h5A);

    // Contention: tone_req held, CPU forced through after MAX_WAIT deferrals
    bus.tone_req = 1'b1; bus.tone_id = 3'd0; bus.tone_a = 5'd0;
    bus.cpu_oe = 1'b1; bus.cpu_id = 3'd1; bus.cpu_a = 5'd3;
    #1;
    chk("cont_c0_ack", {7'd0, bus.tone_ack}, 8'd1);
    step();
    bus.cpu_oe = 1'b0;
    chk("cont_c1_ack", {7'd0, bus.tone_ack}, 8'd1);
    step();
    chk("cont_c2_ack", {7'd0, bus.tone_ack}, 8'd1);
    chk("cont_c2_tqen", {7'd0, bus.tone_q_en}, 8'd1);
    chk("cont_c2_tq", bus.tone_q, 8'hA0);
    step();
    chk("cont_c3_ack", {7'd0, bus.tone_ack}, 8'd1);
    step();
    chk("cont_c4_ack", {7'd0, bus.tone_ack}, 8'd0);
    chk("cont_c4_cqen", {7'd0, bus.cpu_q_en}, 8'd0);
    step();
    chk("cont_c5_ack", {7'd0, bus.tone_ack}, 8'd1);
    chk("cont_c5_ram_a", bus.ram_a, 8'h23);
    chk("cont_c5_cqen", {7'd0, bus.cpu_q_en}, 8'd0);
    step();
    bus.tone_req = 1'b0;
    chk("cont_c6_cqen", {7'd0, bus.cpu_q_en}, 8'd1);
    chk("cont_c6_cq", bus.cpu_q, 8'h3C);
    chk("cont_c6_tqen", {7'd0, bus.tone_q_en}, 8'd0);
    step(); step(); step();

    // SCC D/E sharing
    scci_enable = 1'b0;
    cpu_write("wr_id3", 3'd3, 5'd0, 8'h11, 1'b1, 8'h60);
    tone_fetch("tone_e_scc", 3'd4, 5'd0, 8'h60, 8'h11);
    scci_enable = 1'b1;
    tone_fetch("tone_e_scci", 3'd4, 5'd0, 8'h80, 8'hE5);

    // SCC-mode write to E is dropped; E reads alias D; invalid id reads FF
    scci_enable = 1'b0;
    cpu_write("wr_id4_drop", 3'd4, 5'd1, 8'h99, 1'b0, 8'h61);
    cpu_read("rd_id4_alias", 3'd4, 5'd0, 8'h60, 8'h11);
    cpu_read("rd_id6_inv", 3'd6, 5'd0, 8'hC0, 8'hFF);
    cpu_write("wr_id7_drop", 3'd7, 5'd2, 8'h42, 1'b0, 8'hE2);
    scci_enable = 1'b1;
    cpu_read("rd_id3_after", 3'd3, 5'd1, 8'h61, 8'h00);

    // Overwrite while tone blocks: only the second write reaches RAM
    bus.tone_req = 1'b1; bus.tone_id = 3'd1; bus.tone_a = 5'd0;
    bus.cpu_we = 1'b1; bus.cpu_id = 3'd0; bus.cpu_a = 5'd1; bus.cpu_d = 8'h01;
    #1;
    chk("ovw_c0_ack", {7'd0, bus.tone_ack}, 8'd1);
    step();
    bus.cpu_a = 5'd2; bus.cpu_d = 8'h02;
    #1;
    chk("ovw_c1_ack", {7'd0, bus.tone_ack}, 8'd1);
    step();
    bus.cpu_we = 1'b0;
    for (int c = 2; c < 5; c++) begin
      chk("ovw_wait_ack", {7'd0, bus.tone_ack}, 8'd1);
      chk("ovw_wait_we", {7'd0, bus.ram_we}, 8'd0);
      step();
    end
    chk("ovw_c5_ack", {7'd0, bus.tone_ack}, 8'd0);
    chk("ovw_c5_we", {7'd0, bus.ram_we}, 8'd0);
    step();
    bus.tone_req = 1'b0;
    chk("ovw_c6_we", {7'd0, bus.ram_we}, 8'd1);
    chk("ovw_c6_a", bus.ram_a, 8'h02);
    chk("ovw_c6_d", bus.ram_d, 8'h02);
    step();
    chk("ovw_c7_we", {7'd0, bus.ram_we}, 8'd0);
    step(); step();
    cpu_read("ovw_rd_a1", 3'd0, 5'd1, 8'h01, 8'h77);
    cpu_read("ovw_rd_a2", 3'd0, 5'd2, 8'h02, 8'h02);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
